rr_mux4_1: RTL and testbench
============================

// Module: rr_mux4_1
// PURPOSE
//  Sequential 4:1 stream multiplexer: the merge-side counterpart of the 1:4
//  demux. Four valid/ready input channels are arbitrated round-robin onto one
//  registered valid/ready output. A 2-bit channel tag records which input each
//  word came from, so a downstream demux1_4 can route the word back out.
// PARAMETERS
//  DATA_W   8   width of each data word
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous reset, active-low
//  in_valid   in   4         bit i: channel i presents a word
//  in_data0   in   DATA_W    channel 0 word
//  in_data1   in   DATA_W    channel 1 word
//  in_data2   in   DATA_W    channel 2 word
//  in_data3   in   DATA_W    channel 3 word
//  in_ready   out  4         bit i: channel i word accepted this cycle
//  out_valid  out  1         output register holds a word
//  out_data   out  DATA_W    output word
//  out_sel    out  2         source channel of out_data (0..3)
//  out_ready  in   1         downstream accepts the output word
// BEHAVIOUR
//  - Reset (rst_n=0, async assert): out_valid=0, out_data=0, out_sel=0,
//    ptr=0. in_ready=0 while rst_n=0. Release is synchronous to clk.
//  - State: 1-entry output buffer. EMPTY when out_valid=0, FULL when
//    out_valid=1. 2-bit priority pointer ptr.
//  - load_en = !out_valid | out_ready, so a word can be taken in the same
//    cycle the held word drains.
//  - Grant (combinational): scan the channels ptr, ptr+1, ptr+2, ptr+3
//    (mod 4). The first channel with in_valid set is granted (index g).
//    No valid input means no grant.
//  - in_ready[i] = load_en & (grant==i). At most one bit is set, and only
//    for a channel whose in_valid is 1.
//  - On a clk edge with a grant and load_en:
//    out_data<=in_data[g], out_sel<=g, out_valid<=1, ptr<=g+1 (mod 4).
//  - On a clk edge with no grant and out_ready=1: out_valid<=0. out_data and
//    out_sel keep their values.
//  - On a clk edge with out_valid=1 and out_ready=0: all outputs hold and
//    in_ready=0 (backpressure). Held data must not change while stalled.
//  - Latency: one cycle from input handshake to out_valid.
//  - Throughput: one word per cycle while out_ready=1 is held.
//  - Fairness: a channel that keeps in_valid asserted is granted within 4
//    output handshakes.
//  - Transitions: EMPTY->FULL on a grant.
//    FULL->FULL on (drain and grant) or on stall.
//    FULL->EMPTY on drain with no grant.
//  - ptr changes only on an accepted input. A stall or idle cycle does not
//    move it.
//  - Reset mid-operation: the buffered word is discarded and out_valid drops
//    at once. The next grant after release starts from channel 0.
// TESTING
//  1 Reset: rst_n=0 with in_valid=4'hF -> out_valid=0, in_ready=0, out_data=0.
//  2 Single channel: in_valid=4'b0100, in_data2=8'hA5, out_ready=1
//    -> next cycle out_valid=1, out_data=A5, out_sel=2.
//  3 Round-robin: in_valid=4'hF held, in_dataN=8'h10+N, out_ready=1
//    -> out_sel sequence 0,1,2,3,0; data 10,11,12,13,10; one word per cycle.
//  4 Backpressure: FULL holding 8'h3C with out_ready=0 for 3 cycles
//    -> in_ready=0, out_data=3C stable. When out_ready returns to 1, the next
//       grant loads in the same cycle.
//  5 Drain to empty: single word, then in_valid=0 with out_ready=1
//    -> out_valid=0 next cycle, ptr unchanged.
//  6 Reset mid-stream: assert rst_n=0 during test 3
//    -> out_valid=0 immediately. After release, the first out_sel is 0.

Source files
------------

// File: rtl/rr_mux4_1.sv
// Round-robin 4:1 valid/ready stream merge. The output is held in one register,
// and each word carries a tag naming the input channel it came from.

module rr_mux4_1_lane (
  input  logic rst_n,
  input  logic load_en,
  input  logic gnt,
  output logic ready
);
  // Ready is forced low while reset is asserted, even between clock edges.
  assign ready = rst_n & load_en & gnt;
endmodule

module rr_mux4_1 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [3:0]        in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  input  logic              out_ready
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        sel;
  } word_t;

  logic [NUM_LANES-1:0][DATA_W-1:0] lane_data;
  logic [1:0]                       ptr;
  logic                             gnt_any;
  logic [1:0]                       gnt_idx;
  logic [NUM_LANES-1:0]             gnt_oh;
  logic                             load_en;
  word_t                            buf_q;

  assign lane_data = {in_data3, in_data2, in_data1, in_data0};
  assign load_en   = !out_valid | out_ready;

  // Walk from the farthest offset back to ptr, so the nearest valid channel wins.
  always_comb begin
    logic [1:0] idx;
    gnt_any = 1'b0;
    gnt_idx = ptr;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (in_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      rr_mux4_1_lane u_lane (
        .rst_n   (rst_n),
        .load_en (load_en),
        .gnt     (gnt_oh[i]),
        .ready   (in_ready[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      buf_q     <= '0;
      ptr       <= 2'd0;
    end else if (load_en) begin
      if (gnt_any) begin
        out_valid    <= 1'b1;
        buf_q.data   <= lane_data[gnt_idx];
        buf_q.sel    <= gnt_idx;
        ptr          <= gnt_idx + 2'd1;
      end else begin
        // Drain with nothing to replace it; the last word stays visible.
        out_valid <= 1'b0;
      end
    end
  end

  assign out_data = buf_q.data;
  assign out_sel  = buf_q.sel;
endmodule

// File: tb/tb_rr_mux4_1.sv
// Directed bench for rr_mux4_1: reset, single channel, rotation, stall,
// drain, mid-stream reset and sparse-request priority.

module tb_rr_mux4_1;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [7:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready;

  int tests = 0;
  int fails = 0;

  rr_mux4_1 #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

  initial begin
    logic [1:0] es;
    rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    in_data0 = 8'h10; in_data1 = 8'h11; in_data2 = 8'h12; in_data3 = 8'h13;

    // Reset with every channel requesting
    #2;
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    tick(); tick();
    chk("rst.in_ready_clk", 32'(in_ready), 32'h0);
    chk("rst.valid_clk", 32'(out_valid), 32'h0);

    // Single channel 2
    rst_n = 1'b1; in_valid = 4'b0100; in_data2 = 8'hA5; #1;
    chk("single.in_ready", 32'(in_ready), 32'h4);
    tick();
    chk_out("single", 1'b1, 8'hA5, 2'd2);

    // Drain to empty; word stays on the bus, pointer stays at 3
    in_valid = 4'b0000; #1;
    chk("drain.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("drain", 1'b0, 8'hA5, 2'd2);
    tick();
    chk_out("idle", 1'b0, 8'hA5, 2'd2);

    // Rotation from ptr=3, all channels busy: 3,0,1,2,3
    in_valid = 4'hF; in_data2 = 8'h12;
    for (int k = 0; k < 5; k++) begin
      es = 2'(3 + k);
      #1;
      chk($sformatf("rr3.in_ready%0d", k), 32'(in_ready), 32'(4'b0001 << es));
      tick();
      chk_out($sformatf("rr3.out%0d", k), 1'b1, 8'h10 + 8'(es), es);
    end

    // Backpressure: load 3C from channel 0, then stall 3 cycles
    in_valid = 4'b0001; in_data0 = 8'h3C;
    tick();
    chk_out("bp.load", 1'b1, 8'h3C, 2'd0);
    out_ready = 1'b0; in_valid = 4'hF; in_data0 = 8'h10;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp.in_ready%0d", k), 32'(in_ready), 32'h0);
      tick();
      chk_out($sformatf("bp.hold%0d", k), 1'b1, 8'h3C, 2'd0);
    end
    out_ready = 1'b1; #1;
    chk("bp.release_ready", 32'(in_ready), 32'h2);
    tick();
    chk_out("bp.release", 1'b1, 8'h11, 2'd1);
    tick();
    chk_out("pre_rst", 1'b1, 8'h12, 2'd2);

    // Mid-stream reset with ptr=3
    rst_n = 1'b0; #1;
    chk_out("midrst", 1'b0, 8'h00, 2'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("midrst.valid_clk", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      es = 2'(k);
      #1;
      chk($sformatf("rr0.in_ready%0d", k), 32'(in_ready), 32'(4'b0001 << es));
      tick();
      chk_out($sformatf("rr0.out%0d", k), 1'b1, 8'h10 + 8'(es), es);
    end

    // Sparse requests from ptr=1: 1, 3, 1
    in_valid = 4'b1010;
    tick();
    chk_out("sparse0", 1'b1, 8'h11, 2'd1);
    tick();
    chk_out("sparse1", 1'b1, 8'h13, 2'd3);
    tick();
    chk_out("sparse2", 1'b1, 8'h11, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
